// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the data-memory responder and its lane datapath:
//   access-size encodings, FSM state encodings, the latched request record,
//   and the address range check.
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

  // Access size as carried on the bus. 2'b10 is reserved and always rejected.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_RSVD = 2'b10,
    SIZE_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  // One request as captured at the accept edge.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    size_e       size;
  } req_t;

  // True when the byte address lies beyond a memory of 2**addr_w words.
  function automatic logic out_of_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bundle between a requester (master) and the memory
//   responder (slave).
//   req_valid/req_ready : request handshake, accepted when both are high
//   addr                : byte address
//   wdata               : store data, right-justified
//   wr                  : 1 = store, 0 = load
//   size                : 00 byte, 01 half, 11 word, 10 reserved
//   rsp_valid           : one-cycle response pulse
//   rdata               : load data, left-justified
//   err                 : qualifies rsp_valid, request rejected
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [1:0]  size;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, addr, wdata, wr, size,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, addr, wdata, wr, size,
    output req_ready, rsp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
//   Combinational big-endian lane steering for one access.
//   addr_lo  : byte offset within the word (lane 0 = bits [31:24])
//   size     : access size
//   wdata    : right-justified store data
//   rword    : full memory word at the addressed index
//   be       : byte enables, be[i] covers word bits [8i+7:8i]
//   wlane    : store data replicated onto every lane the size could hit
//   rjust    : addressed byte/half/word moved to the top, low bits zero
//   misalign : reserved size or address not aligned to the size
// ---------------------------------------------------------------------------
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rjust,
  output logic        misalign
);

  // Shifting left by the lane offset brings the addressed lane to [31:24].
  logic [31:0] shifted;
  assign shifted = rword << {addr_lo, 3'b000};

  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    be       = 4'b0000;
    wlane    = 32'd0;
    rjust    = 32'd0;
    misalign = 1'b0;
    unique case (size)
      SIZE_BYTE: begin
        be    = 4'b1000 >> addr_lo;
        wlane = {4{wdata[7:0]}};
        rjust = {shifted[31:24], 24'd0};
      end
      SIZE_HALF: begin
        if (addr_lo[0]) begin
          misalign = 1'b1;
        end else begin
          be    = addr_lo[1] ? 4'b0011 : 4'b1100;
          wlane = {2{wdata[15:0]}};
          rjust = {shifted[31:16], 16'd0};
        end
      end
      SIZE_WORD: begin
        if (addr_lo != 2'b00) begin
          misalign = 1'b1;
        end else begin
          be    = 4'b1111;
          wlane = wdata;
          rjust = rword;
        end
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Single-ported big-endian data memory behind a valid/ready request port.
//   One request is in flight at a time; the response pulse arrives LATENCY
//   cycles after the accept edge and the responder takes a new request one
//   cycle later.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : request/response bundle (slave side)
// Parameters:
//   ADDR_W  : word-index width, memory holds 2**ADDR_W 32-bit words
//   LATENCY : accept-to-response cycles, 1..7
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e      state;
  logic [2:0]  cnt;
  req_t        held;
  logic        rsp_valid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  // The request being worked on: live bus fields while idle (so a LATENCY=1
  // response can be formed at the accept edge), the latched copy otherwise.
  req_t               cur;
  logic [ADDR_W-1:0]  idx;
  logic [3:0]         be;
  logic [31:0]        wlane;
  logic [31:0]        rjust;
  logic               misalign;
  logic               err_now;
  logic               to_resp;

  always_comb begin
    cur = held;
    if (state == IDLE) begin
      cur.addr  = bus.addr;
      cur.wdata = bus.wdata;
      cur.wr    = bus.wr;
      cur.size  = size_e'(bus.size);
    end
  end

  assign idx = cur.addr[ADDR_W+1:2];

  dmem_lane_align u_align (
    .addr_lo  (cur.addr[1:0]),
    .size     (cur.size),
    .wdata    (cur.wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wlane    (wlane),
    .rjust    (rjust),
    .misalign (misalign)
  );

  assign err_now = misalign | out_of_range(cur.addr, ADDR_W);

  // Edge that moves the FSM into RESP; the response registers load here.
  assign to_resp = ((state == IDLE) && bus.req_valid && (LATENCY == 1)) ||
                   ((state == BUSY) && (cnt == 3'd0));

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      held        <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      if (to_resp) begin
        rsp_valid_q <= 1'b1;
        err_q       <= err_now;
        rdata_q     <= (err_now || cur.wr) ? 32'd0 : rjust;
      end

      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            held <= cur;
            if (LATENCY > 1) begin
              state <= BUSY;
              cnt   <= 3'(LATENCY - 2);
            end else begin
              state <= RESP;
            end
          end
        end
        BUSY: begin
          if (cnt == 3'd0) state <= RESP;
          else             cnt   <= cnt - 3'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset branch; clearing it would need a per-word
  // reset network and its contents are meant to survive reset. Holding reset
  // low forces the FSM out of RESP, so a pending store never commits.
  always_ff @(posedge clk) begin
    if (reset && (state == RESP) && held.wr && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Table of load/store vectors pushed through a scoreboard, plus directed
//   sequences for reset state, back-to-back throughput and reset during an
//   in-flight store.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   quiet_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // rdata/err must stay zero whenever no response is signalled.
  always @(negedge clk) begin
    if (!bus.rsp_valid && (bus.err || (bus.rdata != 32'd0))) quiet_bad++;
  end

  // One request: wait for ready, push expectation, then wait for the pulse.
  task automatic transact(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rdata, input string name);
    int   k;
    bit   got;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.wr        = wr;
    bus.size      = size;
    bus.addr      = addr;
    bus.wdata     = wdata;
    k = 0;
    while (!bus.req_ready && k < TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      check({name, "/accept_timeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    sb.push_back('{exp_err, exp_rdata});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= TIMEOUT && !got; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        e = sb.pop_front();
        check({name, "/latency"}, c, LATENCY);
        check({name, "/err"}, {31'd0, bus.err}, {31'd0, e.err});
        check({name, "/rdata"}, bus.rdata, e.rdata);
      end
    end
    if (!got) begin
      check({name, "/rsp_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rdy_seen;
    logic [8:0] rsp_seen;
    int         hits;
    exp_t       e;

    bus.req_valid = 1'b0;
    bus.wr        = 1'b0;
    bus.size      = 2'b00;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, bus.req_ready, bus.rsp_valid, bus.err, 1'b0},
          {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_rdata", bus.rdata, 32'd0);
    reset = 1'b1;

    // {wr, size, addr, wdata, exp_err, exp_rdata}
    vecs.push_back('{1'b1, SIZE_WORD, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, SIZE_HALF, 32'h12,       32'h0,        1'b0, 32'hBEEF0000});
    vecs.push_back('{1'b0, SIZE_HALF, 32'h13,       32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, SIZE_BYTE, 32'h11,       32'h000000AA, 1'b0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 32'h10,       32'h0,        1'b0, 32'hDEAABEEF});
    vecs.push_back('{1'b0, SIZE_BYTE, 32'h11,       32'h0,        1'b0, 32'hAA000000});
    vecs.push_back('{1'b0, SIZE_BYTE, 32'h13,       32'h0,        1'b0, 32'hEF000000});
    vecs.push_back('{1'b0, SIZE_HALF, 32'h10,       32'h0,        1'b0, 32'hDEAA0000});
    vecs.push_back('{1'b1, SIZE_WORD, 32'h0,        32'h01234567, 1'b0, 32'h0});
    vecs.push_back('{1'b1, SIZE_WORD, 32'h1000,     32'hFFFFFFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 32'h0,        32'h0,        1'b0, 32'h01234567});
    vecs.push_back('{1'b0, SIZE_WORD, 32'h12,       32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b0, 2'b10,     32'h0,        32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, SIZE_HALF, 32'h2,        32'hFFFF5A5A, 1'b0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 32'h0,        32'h0,        1'b0, 32'h01235A5A});
    vecs.push_back('{1'b1, SIZE_BYTE, 32'h3,        32'h123456C3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 32'h0,        32'h0,        1'b0, 32'h01235AC3});
    vecs.push_back('{1'b1, SIZE_WORD, 32'hFFC,      32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 32'hFFC,      32'h0,        1'b0, 32'hCAFEF00D});
    vecs.push_back('{1'b0, SIZE_BYTE, 32'h80000010, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, SIZE_HALF, 32'h11,       32'h00001234, 1'b1, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 32'h10,       32'h0,        1'b0, 32'hDEAABEEF});

    foreach (vecs[i]) begin
      transact(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Back-to-back: req_valid held high, accepts every LATENCY+1 cycles.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.wr        = 1'b0;
    bus.size      = SIZE_WORD;
    bus.addr      = 32'h0;
    for (int c = 0; c < 9; c++) begin
      rdy_seen[c] = bus.req_ready;
      rsp_seen[c] = bus.rsp_valid;
      if (bus.rsp_valid) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check($sformatf("b2b_rdata%0d", c), bus.rdata, e.rdata);
        end else begin
          check($sformatf("b2b_unexpected_rsp%0d", c), 32'd1, 32'd0);
        end
      end
      if (bus.req_ready) sb.push_back('{1'b0, 32'h01235AC3});
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b_ready_pattern", {23'd0, rdy_seen}, {23'd0, 9'b001_001_001});
    check("b2b_rsp_pattern",   {23'd0, rsp_seen}, {23'd0, 9'b100_100_100});
    check("b2b_sb_drained", sb.size(), 32'd0);
    sb.delete();

    // Reset while a store is in flight: no response, memory untouched.
    transact(1'b1, SIZE_WORD, 32'h20, 32'h11112222, 1'b0, 32'h0, "st20");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.wr        = 1'b1;
    bus.size      = SIZE_WORD;
    bus.addr      = 32'h20;
    bus.wdata     = 32'h99999999;
    check("rst_seq_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_midflight_outputs", {28'd0, bus.req_ready, bus.rsp_valid, bus.err, 1'b0},
          {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    hits = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid) hits++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) hits++;
    end
    check("rst_no_rsp", hits, 32'd0);
    transact(1'b0, SIZE_WORD, 32'h20, 32'h0, 1'b0, 32'h11112222, "ld20_after_rst");

    check("quiet_outputs", quiet_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
